// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module : y86_pkg
// Brief  : Shared Y86-64 encodings plus the M pipeline register layout.
// Rev    : 1.0  initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
    } mreg_t;

    function automatic mreg_t mreg_bubble();
        mreg_t b;
        b.stat  = SAOK;
        b.icode = INOP;
        b.cnd   = 1'b0;
        b.valE  = 64'd0;
        b.valA  = 64'd0;
        b.dstE  = RNONE;
        b.dstM  = RNONE;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/execute_if.sv
`default_nettype none
// ============================================================================
// Module : execute_if
// Brief  : E-register inputs, forwarding taps and M-register outputs.
// Rev    : 1.0  initial release
// ============================================================================
interface execute_if;
    logic [2:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [63:0] E_valC;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [2:0]  m_stat;
    logic [2:0]  W_stat;
    logic        M_bubble;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [2:0]  cc;
    logic [2:0]  M_stat;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valE;
    logic [63:0] M_valA;
    logic [3:0]  M_dstE;
    logic [3:0]  M_dstM;

    modport master (
        output E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        output m_stat, W_stat, M_bubble,
        input  e_valE, e_dstE, e_Cnd, cc,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
        input  m_stat, W_stat, M_bubble,
        output e_valE, e_dstE, e_Cnd, cc,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Brief  : Combinational 64-bit Y86 ALU computing B op A with flags.
// Rev    : 1.0  initial release
// ============================================================================
module alu
    import y86_pkg::*;
(
    input  logic [63:0] aluA,
    input  logic [63:0] aluB,
    input  logic [3:0]  alufun,
    output logic [63:0] result,
    output logic        zf,
    output logic        sf,
    output logic        of
);
    logic [63:0] w_sum;
    logic [63:0] w_diff;

    assign w_sum  = aluB + aluA;
    assign w_diff = aluB - aluA;

    always_comb begin
        result = 64'd0;
        of     = 1'b0;
        case (alufun)
            ALUADD: begin
                result = w_sum;
                of     = (aluA[63] == aluB[63]) && (w_sum[63] != aluA[63]);
            end
            ALUSUB: begin
                result = w_diff;
                of     = (aluA[63] != aluB[63]) && (w_diff[63] != aluB[63]);
            end
            ALUAND:  result = aluB & aluA;
            ALUXOR:  result = aluB ^ aluA;
            default: result = 64'd0;
        endcase
    end

    assign zf = (result == 64'd0);
    assign sf = result[63];
endmodule
`default_nettype wire

// File: rtl/execute.sv
`default_nettype none
// ============================================================================
// Module : execute
// Brief  : Y86-64 execute stage: ALU, CC register, conditions, M register.
// Rev    : 1.0  initial release
// ============================================================================
module execute
    import y86_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    execute_if.slave  ex
);
    logic [63:0] w_aluA;
    logic [63:0] w_aluB;
    logic [3:0]  w_alufun;
    logic [63:0] w_result;
    logic        w_zf;
    logic        w_sf;
    logic        w_of;
    logic        w_set_cc;
    logic        w_cond;
    logic        w_cnd;
    logic [3:0]  w_dstE;
    logic [2:0]  cc_d, cc_q;
    mreg_t       m_d, m_q;

    always_comb begin
        w_aluA = 64'd0;
        case (ex.E_icode)
            IRRMOVQ, IOPQ:             w_aluA = ex.E_valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: w_aluA = ex.E_valC;
            ICALL, IPUSHQ:             w_aluA = -64'sd8;
            IRET, IPOPQ:               w_aluA = 64'd8;
            default:                   w_aluA = 64'd0;
        endcase
    end

    always_comb begin
        w_aluB = 64'd0;
        case (ex.E_icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: w_aluB = ex.E_valB;
            default:                                            w_aluB = 64'd0;
        endcase
    end

    assign w_alufun = (ex.E_icode == IOPQ) ? ex.E_ifun : ALUADD;

    alu u_alu (
        .aluA   (w_aluA),
        .aluB   (w_aluB),
        .alufun (w_alufun),
        .result (w_result),
        .zf     (w_zf),
        .sf     (w_sf),
        .of     (w_of)
    );

    // Any faulting instruction further down the pipe freezes the flags.
    assign w_set_cc = (ex.E_icode == IOPQ) && (ex.E_stat == SAOK) &&
                      (ex.m_stat == SAOK) && (ex.W_stat == SAOK);
    assign cc_d     = w_set_cc ? {w_zf, w_sf, w_of} : cc_q;

    always_comb begin
        w_cond = 1'b0;
        case (ex.E_ifun)
            C_YES:   w_cond = 1'b1;
            C_LE:    w_cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
            C_L:     w_cond = cc_q[1] ^ cc_q[0];
            C_E:     w_cond = cc_q[2];
            C_NE:    w_cond = ~cc_q[2];
            C_GE:    w_cond = ~(cc_q[1] ^ cc_q[0]);
            C_G:     w_cond = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
            default: w_cond = 1'b0;
        endcase
    end

    assign w_cnd  = ((ex.E_icode == IRRMOVQ) || (ex.E_icode == IJXX)) ? w_cond : 1'b0;
    assign w_dstE = ((ex.E_icode == IRRMOVQ) && !w_cnd) ? RNONE : ex.E_dstE;

    always_comb begin
        m_d       = mreg_bubble();
        if (!ex.M_bubble) begin
            m_d.stat  = ex.E_stat;
            m_d.icode = ex.E_icode;
            m_d.cnd   = w_cnd;
            m_d.valE  = w_result;
            m_d.valA  = ex.E_valA;
            m_d.dstE  = w_dstE;
            m_d.dstM  = ex.E_dstM;
        end
    end

    // The E register loads on the falling edge, so M and CC follow it.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
            m_q  <= mreg_bubble();
        end else begin
            cc_q <= cc_d;
            m_q  <= m_d;
        end
    end

    assign ex.e_valE   = w_result;
    assign ex.e_dstE   = w_dstE;
    assign ex.e_Cnd    = w_cnd;
    assign ex.cc       = cc_q;
    assign ex.M_stat   = m_q.stat;
    assign ex.M_icode  = m_q.icode;
    assign ex.M_Cnd    = m_q.cnd;
    assign ex.M_valE   = m_q.valE;
    assign ex.M_valA   = m_q.valA;
    assign ex.M_dstE   = m_q.dstE;
    assign ex.M_dstM   = m_q.dstM;
endmodule
`default_nettype wire

// File: tb/tb_execute.sv
`default_nettype none
// ============================================================================
// Module : tb_execute
// Brief  : Scoreboard bench for execute: directed cases, reset, random stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_execute;
    import y86_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    execute_if ex_if ();
    execute u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (ex_if)
    );

    typedef struct {
        logic [63:0] valE;
        logic [3:0]  dstE;
        logic        cnd;
        logic [2:0]  mstat;
        logic [3:0]  micode;
        logic        mcnd;
        logic [63:0] mvalE;
        logic [63:0] mvalA;
        logic [3:0]  mdstE;
        logic [3:0]  mdstM;
        logic [2:0]  cc;
    } exp_t;

    exp_t       q[$];
    exp_t       me;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] model_cc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_raw(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ifn,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [3:0] de, input logic [3:0] dm,
                             input logic [2:0] ms, input logic [2:0] ws, input logic bub);
        ex_if.E_stat   = st;
        ex_if.E_icode  = ic;
        ex_if.E_ifun   = ifn;
        ex_if.E_valA   = a;
        ex_if.E_valB   = b;
        ex_if.E_valC   = c;
        ex_if.E_dstE   = de;
        ex_if.E_dstM   = dm;
        ex_if.m_stat   = ms;
        ex_if.W_stat   = ws;
        ex_if.M_bubble = bub;
    endtask

    // Reference model: instruction semantics straight from the ISA description.
    task automatic issue(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] ifn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [3:0] de, input logic [3:0] dm,
                         input logic [2:0] ms, input logic [2:0] ws, input logic bub);
        exp_t        e;
        logic [64:0] wide;
        logic [63:0] v;
        logic        ovf, z, s, o, cnd, setcc;
        @(posedge clk);
        #1;
        drive_raw(st, ic, ifn, a, b, c, de, dm, ms, ws, bub);
        z   = model_cc[2];
        s   = model_cc[1];
        o   = model_cc[0];
        v   = 64'd0;
        ovf = 1'b0;
        case (ic)
            4'h2: v = a;
            4'h3: v = c;
            4'h4, 4'h5: v = b + c;
            4'h8, 4'hA: v = b - 64'd8;
            4'h9, 4'hB: v = b + 64'd8;
            4'h6: begin
                case (ifn)
                    4'h0: begin wide = {b[63], b} + {a[63], a}; v = wide[63:0]; ovf = wide[64] ^ wide[63]; end
                    4'h1: begin wide = {b[63], b} - {a[63], a}; v = wide[63:0]; ovf = wide[64] ^ wide[63]; end
                    4'h2: v = a & b;
                    4'h3: v = a ^ b;
                    default: v = 64'd0;
                endcase
            end
            default: v = 64'd0;
        endcase
        case (ifn)
            4'h0: cnd = 1'b1;
            4'h1: cnd = (s != o) || z;
            4'h2: cnd = (s != o);
            4'h3: cnd = z;
            4'h4: cnd = !z;
            4'h5: cnd = (s == o);
            4'h6: cnd = (s == o) && !z;
            default: cnd = 1'b0;
        endcase
        if (ic != 4'h2 && ic != 4'h7) cnd = 1'b0;
        e.valE = v;
        e.cnd  = cnd;
        e.dstE = (ic == 4'h2 && !cnd) ? 4'hF : de;
        if (bub) begin
            e.mstat = 3'd1; e.micode = 4'h1; e.mcnd = 1'b0;
            e.mvalE = 64'd0; e.mvalA = 64'd0; e.mdstE = 4'hF; e.mdstM = 4'hF;
        end else begin
            e.mstat = st; e.micode = ic; e.mcnd = cnd;
            e.mvalE = v; e.mvalA = a; e.mdstE = e.dstE; e.mdstM = dm;
        end
        setcc    = (ic == 4'h6) && (st == 3'd1) && (ms == 3'd1) && (ws == 3'd1);
        e.cc     = setcc ? {v == 64'd0, v[63], ovf} : model_cc;
        model_cc = e.cc;
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0) begin
                me = q.pop_front();
                chk("e_valE", ex_if.e_valE, me.valE);
                chk("e_dstE", 64'(ex_if.e_dstE), 64'(me.dstE));
                chk("e_Cnd", 64'(ex_if.e_Cnd), 64'(me.cnd));
                @(negedge clk);
                #1;
                chk("M_stat", 64'(ex_if.M_stat), 64'(me.mstat));
                chk("M_icode", 64'(ex_if.M_icode), 64'(me.micode));
                chk("M_Cnd", 64'(ex_if.M_Cnd), 64'(me.mcnd));
                chk("M_valE", ex_if.M_valE, me.mvalE);
                chk("M_valA", ex_if.M_valA, me.mvalA);
                chk("M_dstE", 64'(ex_if.M_dstE), 64'(me.mdstE));
                chk("M_dstM", 64'(ex_if.M_dstM), 64'(me.mdstM));
                chk("cc", 64'(ex_if.cc), 64'(me.cc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 3))
            0: return {$urandom(), $urandom()};
            1: return 64'($urandom_range(0, 16));
            2: return ($urandom_range(0, 1) != 0) ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000;
            default: return -64'($urandom_range(1, 16));
        endcase
    endfunction

    function automatic logic [2:0] rstat();
        return ($urandom_range(0, 9) < 8) ? 3'd1 : 3'($urandom_range(1, 4));
    endfunction

    initial begin
        logic [3:0]  ic, ifn;
        logic [63:0] a, b;
        rst_n = 1'b0;
        drive_raw(SAOK, INOP, 4'h0, 64'd0, 64'd0, 64'd0, RNONE, RNONE, SAOK, SAOK, 1'b0);
        model_cc = 3'b100;
        repeat (2) @(posedge clk);
        #1;
        chk("reset cc", 64'(ex_if.cc), 64'h4);
        chk("reset M_icode", 64'(ex_if.M_icode), 64'h1);
        chk("reset M_dstE", 64'(ex_if.M_dstE), 64'hF);
        #1;
        rst_n = 1'b1;

        issue(SAOK, IOPQ, ALUADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IOPQ, ALUSUB, 64'd5, 64'd5, 64'd0, 4'h3, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IRRMOVQ, C_E, 64'hABC, 64'd0, 64'd0, 4'h4, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IRRMOVQ, C_NE, 64'hABC, 64'd0, 64'd0, 4'h4, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IOPQ, ALUXOR, 64'd3, 64'd6, 64'd0, 4'h5, RNONE, SADR, SAOK, 1'b0);
        issue(SAOK, IPUSHQ, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IPOPQ, 4'h0, 64'h55, 64'h100, 64'd0, 4'h4, 4'h2, SAOK, SAOK, 1'b0);
        issue(SAOK, IMRMOVQ, 4'h0, 64'd0, 64'h20, 64'h10, RNONE, 4'h2, SAOK, SAOK, 1'b0);
        issue(SAOK, IOPQ, ALUSUB, 64'd5, 64'd3, 64'd0, 4'h6, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IJXX, C_LE, 64'd0, 64'd0, 64'h400, RNONE, RNONE, SAOK, SAOK, 1'b0);
        issue(SAOK, IJXX, C_G, 64'd0, 64'd0, 64'h400, RNONE, RNONE, SAOK, SAOK, 1'b0);

        // Park a non-OPq instruction so M holds non-bubble contents, then reset between edges.
        @(posedge clk);
        #1;
        drive_raw(SAOK, IIRMOVQ, 4'h0, 64'd0, 64'd0, 64'h77, 4'h5, RNONE, SAOK, SAOK, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_cc = 3'b100;
        chk("async rst M_icode", 64'(ex_if.M_icode), 64'h1);
        chk("async rst M_dstE", 64'(ex_if.M_dstE), 64'hF);
        chk("async rst M_valE", ex_if.M_valE, 64'd0);
        chk("async rst cc", 64'(ex_if.cc), 64'h4);
        @(negedge clk);
        #1;
        chk("rst hold M_icode", 64'(ex_if.M_icode), 64'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue(SAOK, IIRMOVQ, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h5, RNONE, SAOK, SAOK, 1'b1);

        for (int i = 0; i < 300; i++) begin
            ic  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15))
                                              : (($urandom_range(0, 2) == 0) ? IRRMOVQ :
                                                 ($urandom_range(0, 1) != 0) ? IOPQ : IJXX);
            ifn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            if (ic == IOPQ && $urandom_range(0, 7) != 0) ifn = 4'($urandom_range(0, 3));
            a = rnd64();
            b = ($urandom_range(0, 5) == 0) ? a : rnd64();
            issue(rstat(), ic, ifn, a, b, rnd64(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  rstat(), rstat(), ($urandom_range(0, 9) == 0));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/execute.md
# execute

Execute stage of the five-stage Y86-64 pipeline, directly downstream of decode. It consumes the E pipeline register, performs ALU arithmetic, holds the condition-code register and evaluates branch/cmov conditions. It drives the combinational e_valE/e_dstE forwarding taps back to decode and owns the M pipeline register feeding the memory stage.

## Interface

Parameters: none.

- `clk` in 1: stage clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `E_stat` in 3: status of the instruction in E.
- `E_icode`, `E_ifun` in 4 each: instruction code and function.
- `E_valA`, `E_valB`, `E_valC` in 64 each: operands and constant from decode.
- `E_dstE`, `E_dstM` in 4 each: destination registers; 4'hF = none.
- `m_stat`, `W_stat` in 3 each: memory-stage and writeback status, used for CC suppression.
- `M_bubble` in 1: load nop into M instead of the E result.
- `e_valE` out 64: ALU result, combinational; forwarding tap.
- `e_dstE` out 4: effective dstE, combinational; forwarding tap.
- `e_Cnd` out 1: condition result, combinational.
- `cc` out 3: {ZF,SF,OF}, registered.
- `M_stat` out 3, `M_icode` out 4, `M_Cnd` out 1, `M_valE` out 64, `M_valA` out 64, `M_dstE` out 4, `M_dstM` out 4: M pipeline register.

## Operation

- Stat codes: AOK=1, HLT=2, ADR=3, INS=4.
- aluA selection:
  - E_valA for cmov (2) and OPq (6).
  - E_valC for irmov (3), rmmov (4), mrmov (5).
  - -8 for call (8) and push (A).
  - +8 for ret (9) and pop (B).
  - 0 otherwise.
- aluB selection:
  - E_valB for icodes 4, 5, 6, 8, 9, A, B.
  - 0 otherwise.
- alufun: E_ifun when icode=6, else ADD.
  - ifun 0 = B+A.
  - ifun 1 = B−A.
  - ifun 2 = B&A.
  - ifun 3 = B^A.
  - ifun >3 produces 0.
- All arithmetic is 64-bit two's complement. Carry out is discarded.
- Flags:
  - ZF = (result==0); SF = result[63].
  - OF for add: A[63]==B[63] && result[63]!=A[63].
  - OF for sub: A[63]!=B[63] && result[63]!=B[63].
  - OF for and/xor: 0.
- CC update is enabled only when all hold: E_icode=6, E_stat=AOK, m_stat=AOK, W_stat=AOK.
- Conditions, evaluated on the current cc for cmov and jxx:
  - ifun 0: 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): !ZF.
  - ifun 5 (ge): !(SF^OF).
  - ifun 6 (g): !(SF^OF)&!ZF.
  - ifun 7–F: 0.
  - e_Cnd = 0 for all other icodes.
- e_dstE = 4'hF when icode=2 and !e_Cnd; otherwise E_dstE.
- M register load, normal: M_stat=E_stat, M_icode=E_icode, M_Cnd=e_Cnd, M_valE=e_valE, M_valA=E_valA, M_dstE=e_dstE, M_dstM=E_dstM.
- M register load, M_bubble=1: stat AOK, icode 1 (nop), Cnd 0, valE 0, valA 0, dstE F, dstM F.

## Timing

- ALU, condition and e_* outputs are purely combinational from E_* and cc.
- The M register and cc both update on the falling edge of clk, the same edge that loads the E register.
- Cond for an instruction sees the flags written by the preceding OPq: that OPq updated cc on the edge this instruction entered E.
- Latency: one edge from E to M.
- Reset, asynchronous on rst_n low:
  - cc = {ZF=1, SF=0, OF=0}.
  - M register = bubble values: stat AOK, icode 1, Cnd 0, values 0, dst F.
  - Reset dominates a coincident clock edge and M_bubble.
- Reset mid-operation discards the in-flight M contents. The first edge after rst_n rises loads normally.
- M_bubble with a CC-updating OPq in E: cc still updates; only the M load is replaced. Upstream control never requests this combination for a valid OPq.
- A bubble in E (icode 1, stat AOK) produces valE 0, Cnd 0, dstE F and no CC change.

## Structure

- Shared package `y86_pkg`:
  - icode constants (NOP…POPQ).
  - ALU ifun constants.
  - condition ifun constants.
  - stat codes.
  - RNONE=4'hF.
- Sub-module `alu`: combinational 64-bit ALU with inputs aluA, aluB, alufun and outputs result, zf, sf, of.
- Condition evaluation and CC register stay in `execute`.

## Test plan

- OPq add, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=0x8000_0000_0000_0000; after edge cc={0,1,1}.
- OPq sub, valA=5, valB=5 -> e_valE=0, cc={1,0,0}. A following cmove rA->rB gives e_dstE=rB; a following cmovne gives e_dstE=F and M_dstE=F.
- OPq xor with m_stat=ADR -> e_valE computed, cc unchanged from prior value.
- push with valB=0x100 -> e_valE=0xF8. pop with valB=0x100 -> e_valE=0x108. mrmov with valC=0x10, valB=0x20 -> 0x30.
- jle after cc={0,1,0} -> e_Cnd=1, M_Cnd=1; jg after same cc -> 0.
- Assert rst_n low mid-stream (asynchronously, between edges) -> M_icode=1, M_dstE=F, cc={1,0,0} immediately. Then M_bubble=1 with irmov in E -> M_icode=1, M_valE=0.
